// File: rtl/lb_resp_pkg.sv
// Shared definitions for the lb_* bus responder: window offsets, region decode
// and the saturating counter increment.
package lb_resp_pkg;

   localparam logic [5:0]  OFF_CTRL      = 6'h00;
   localparam logic [5:0]  OFF_STAT      = 6'h10;
   localparam logic [5:0]  OFF_STICKY    = 6'h20;
   localparam logic [5:0]  OFF_MASK      = 6'h21;
   localparam logic [5:0]  OFF_WCNT      = 6'h22;
   localparam logic [5:0]  OFF_ECNT      = 6'h23;
   localparam logic [5:0]  OFF_ID        = 6'h24;
   localparam logic [31:0] UNMAPPED_WORD = 32'hDEADBEEF;

   typedef enum logic [2:0] {
      REG_CTRL,
      REG_STAT,
      REG_STICKY,
      REG_MASK,
      REG_WCNT,
      REG_ECNT,
      REG_ID,
      REG_NONE
   } region_e;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

   function automatic region_e decode_offset(input logic [5:0] off,
                                             input int         n_ctrl,
                                             input int         n_stat);
      region_e r;
      r = REG_NONE;
      if (off < OFF_CTRL + 6'(n_ctrl)) begin
         r = REG_CTRL;
      end else if (off >= OFF_STAT && off < OFF_STAT + 6'(n_stat)) begin
         r = REG_STAT;
      end else begin
         case (off)
            OFF_STICKY: r = REG_STICKY;
            OFF_MASK:   r = REG_MASK;
            OFF_WCNT:   r = REG_WCNT;
            OFF_ECNT:   r = REG_ECNT;
            OFF_ID:     r = REG_ID;
            default:    r = REG_NONE;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/lb_read_pipe.sv
// Valid+data delay line for read responses. The final stage holds its data
// between valids so the master sees a stable lb_din.
module lb_read_pipe #(
   parameter int DEPTH = 2,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   logic [DEPTH-1:0]        valid_q, valid_d;
   logic [DEPTH-1:0][W-1:0] data_q, data_d;

   // A stage only loads data alongside a valid, so idle cycles never disturb it.
   always_comb begin
      valid_d    = '0;
      data_d     = data_q;
      valid_d[0] = in_valid;
      if (in_valid) data_d[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         valid_d[i] = valid_q[i-1];
         if (valid_q[i-1]) data_d[i] = data_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/lb_ctl_responder.sv
// Target end of the lb_* local bus: 64-word window of control, status, sticky
// event, mask and counter registers with fixed-latency read return.
module lb_ctl_responder
   import lb_resp_pkg::*;
#(
   parameter logic [23:0] BASE_ADDR    = 24'h010000,
   parameter int          N_CTRL       = 8,
   parameter int          N_STAT       = 8,
   parameter int          READ_LAT     = 3,
   parameter logic [31:0] CTRL_DEFAULT = 32'h0,
   parameter logic [31:0] ID_WORD      = 32'h4C524553
) (
   input  logic                  lb_clk,
   input  logic                  lb_rstn,
   input  logic [23:0]           lb_addr,
   input  logic                  lb_strobe,
   input  logic                  lb_rd,
   input  logic                  lb_write,
   input  logic [31:0]           lb_data,
   output logic [31:0]           lb_din,
   output logic                  lb_rd_valid,
   output logic [32*N_CTRL-1:0]  ctrl_out,
   output logic [N_CTRL-1:0]     ctrl_we,
   input  logic [32*N_STAT-1:0]  stat_in,
   input  logic [31:0]           event_in,
   output logic                  irq
);

   localparam int PIPE_DEPTH = READ_LAT - 1;

   logic [5:0]              offset;
   logic [3:0]              idx;
   logic                    hit;
   logic                    wr_acc;
   logic                    rd_acc;
   region_e                 region;
   logic [N_STAT-1:0][31:0] stat_w;
   logic [31:0]             rd_word;
   logic [31:0]             w1c;

   logic [N_CTRL-1:0][31:0] ctrl_q, ctrl_d;
   logic [N_CTRL-1:0]       ctrl_we_q, ctrl_we_d;
   logic [31:0]             sticky_q, sticky_d;
   logic [31:0]             mask_q, mask_d;
   logic [31:0]             wcnt_q, wcnt_d;
   logic [31:0]             ecnt_q, ecnt_d;
   logic                    irq_q, irq_d;
   logic                    rd_valid_q, rd_valid_d;
   logic [31:0]             rd_data_q, rd_data_d;

   assign offset = lb_addr[5:0];
   assign idx    = offset[3:0];
   assign hit    = (lb_addr[23:6] == BASE_ADDR[23:6]);
   assign region = decode_offset(offset, N_CTRL, N_STAT);
   assign stat_w = stat_in;

   // A strobe with both lb_rd and lb_write set is treated as a read.
   assign wr_acc = lb_strobe & lb_write & ~lb_rd & hit;
   assign rd_acc = lb_strobe & lb_rd & hit;

   // NOTE: every output of this block gets a default first, so no path through
   // the case/if tree can leave a signal unassigned and infer a latch.
   always_comb begin
      rd_word = UNMAPPED_WORD;
      case (region)
         REG_CTRL: begin
            for (int k = 0; k < N_CTRL; k++) begin
               if (idx == 4'(k)) rd_word = ctrl_q[k];
            end
         end
         REG_STAT: begin
            for (int k = 0; k < N_STAT; k++) begin
               if (idx == 4'(k)) rd_word = stat_w[k];
            end
         end
         REG_STICKY: rd_word = sticky_q;
         REG_MASK:   rd_word = mask_q;
         REG_WCNT:   rd_word = wcnt_q;
         REG_ECNT:   rd_word = ecnt_q;
         REG_ID:     rd_word = ID_WORD;
         default:    rd_word = UNMAPPED_WORD;
      endcase
   end

   always_comb begin
      ctrl_d    = ctrl_q;
      ctrl_we_d = '0;
      mask_d    = mask_q;
      wcnt_d    = wcnt_q;
      ecnt_d    = ecnt_q;
      w1c       = '0;

      if (wr_acc) begin
         wcnt_d = sat_inc(wcnt_q);
         case (region)
            REG_CTRL: begin
               for (int k = 0; k < N_CTRL; k++) begin
                  if (idx == 4'(k)) begin
                     ctrl_d[k]    = lb_data;
                     ctrl_we_d[k] = 1'b1;
                  end
               end
            end
            REG_STICKY: w1c    = lb_data;
            REG_MASK:   mask_d = lb_data;
            default:    ecnt_d = sat_inc(ecnt_q);
         endcase
      end

      if (rd_acc && region == REG_NONE) ecnt_d = sat_inc(ecnt_q);

      // A new event on a bit beats a clear of that bit in the same cycle.
      sticky_d = (sticky_q & ~w1c) | event_in;
      irq_d    = |(sticky_q & mask_q);

      // Stage 1 of the read path: everything is sampled at the strobe edge.
      rd_valid_d = rd_acc;
      rd_data_d  = rd_word;
   end

   // NOTE: non-blocking assignments so every flop samples the pre-edge values,
   // regardless of the order of the statements below.
   always_ff @(posedge lb_clk or negedge lb_rstn) begin
      if (!lb_rstn) begin
         // NOTE: the control bank is a set of individual flops with a defined
         // power-up value, so it is reset unlike the contents of a RAM.
         ctrl_q     <= {N_CTRL{CTRL_DEFAULT}};
         ctrl_we_q  <= '0;
         sticky_q   <= '0;
         mask_q     <= '0;
         wcnt_q     <= '0;
         ecnt_q     <= '0;
         irq_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         ctrl_we_q  <= ctrl_we_d;
         sticky_q   <= sticky_d;
         mask_q     <= mask_d;
         wcnt_q     <= wcnt_d;
         ecnt_q     <= ecnt_d;
         irq_q      <= irq_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   lb_read_pipe #(
      .DEPTH (PIPE_DEPTH),
      .W     (32)
   ) u_read_pipe (
      .clk       (lb_clk),
      .rst_n     (lb_rstn),
      .in_valid  (rd_valid_q),
      .in_data   (rd_data_q),
      .out_valid (lb_rd_valid),
      .out_data  (lb_din)
   );

   assign ctrl_out = ctrl_q;
   assign ctrl_we  = ctrl_we_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_lb_ctl_responder.sv
// Self-checking bench for lb_ctl_responder: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_lb_ctl_responder;

   localparam logic [23:0] BASE = 24'h010000;
   localparam int          NC   = 8;
   localparam int          NS   = 8;
   localparam int          RL   = 3;
   localparam logic [31:0] DEF  = 32'h0;
   localparam logic [31:0] ID   = 32'h4C524553;

   logic              lb_clk    = 1'b0;
   logic              lb_rstn   = 1'b0;
   logic [23:0]       lb_addr   = '0;
   logic              lb_strobe = 1'b0;
   logic              lb_rd     = 1'b0;
   logic              lb_write  = 1'b0;
   logic [31:0]       lb_data   = '0;
   logic [31:0]       lb_din;
   logic              lb_rd_valid;
   logic [32*NC-1:0]  ctrl_out;
   logic [NC-1:0]     ctrl_we;
   logic [32*NS-1:0]  stat_in   = '0;
   logic [31:0]       event_in  = '0;
   logic              irq;

   always #5 lb_clk = ~lb_clk;

   lb_ctl_responder #(
      .BASE_ADDR    (BASE),
      .N_CTRL       (NC),
      .N_STAT       (NS),
      .READ_LAT     (RL),
      .CTRL_DEFAULT (DEF),
      .ID_WORD      (ID)
   ) dut (
      .lb_clk      (lb_clk),
      .lb_rstn     (lb_rstn),
      .lb_addr     (lb_addr),
      .lb_strobe   (lb_strobe),
      .lb_rd       (lb_rd),
      .lb_write    (lb_write),
      .lb_data     (lb_data),
      .lb_din      (lb_din),
      .lb_rd_valid (lb_rd_valid),
      .ctrl_out    (ctrl_out),
      .ctrl_we     (ctrl_we),
      .stat_in     (stat_in),
      .event_in    (event_in),
      .irq         (irq)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      longint      due;
      logic [31:0] data;
   } rsp_t;

   logic [31:0] m_ctrl [NC];
   logic [31:0] m_sticky, m_mask, m_din;
   longint      m_wcnt, m_ecnt, m_cyc;
   logic [NC-1:0] m_we;
   logic        m_valid, m_irq;
   rsp_t        m_q[$];

   function automatic longint sat(input longint v);
      return (v >= 64'hFFFFFFFF) ? 64'hFFFFFFFF : v + 1;
   endfunction

   function automatic bit m_mapped(input int o);
      return (o < NC) || (o >= 16 && o < 16 + NS) || (o >= 32 && o <= 36);
   endfunction

   function automatic logic [31:0] m_lookup(input int o);
      if (o < NC) return m_ctrl[o];
      if (o >= 16 && o < 16 + NS) return stat_in[32*(o-16) +: 32];
      case (o)
         32: return m_sticky;
         33: return m_mask;
         34: return m_wcnt[31:0];
         35: return m_ecnt[31:0];
         36: return ID;
         default: return 32'hDEADBEEF;
      endcase
   endfunction

   function automatic logic [32*NC-1:0] m_ctrl_flat();
      logic [32*NC-1:0] f;
      for (int k = 0; k < NC; k++) f[32*k +: 32] = m_ctrl[k];
      return f;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NC; k++) m_ctrl[k] = DEF;
      m_sticky = '0; m_mask = '0; m_wcnt = 0; m_ecnt = 0;
      m_we = '0; m_valid = 1'b0; m_din = '0; m_irq = 1'b0;
      m_q.delete();
   endtask

   task automatic model_step();
      int          o;
      bit          in_win, rd_a, wr_a;
      logic [31:0] old_sticky, old_mask, w1c;
      if (!lb_rstn) begin
         model_reset();
         return;
      end
      m_cyc++;
      o          = int'(lb_addr[5:0]);
      in_win     = (lb_addr / 64) == (BASE / 64);
      rd_a       = lb_strobe && lb_rd && in_win;
      wr_a       = lb_strobe && lb_write && !lb_rd && in_win;
      old_sticky = m_sticky;
      old_mask   = m_mask;
      w1c        = '0;
      m_we       = '0;
      if (rd_a) begin
         m_q.push_back('{m_cyc + RL - 1, m_lookup(o)});
         if (!m_mapped(o)) m_ecnt = sat(m_ecnt);
      end
      if (wr_a) begin
         m_wcnt = sat(m_wcnt);
         if (o < NC) begin
            m_ctrl[o] = lb_data;
            m_we[o]   = 1'b1;
         end else if (o == 32) w1c = lb_data;
         else if (o == 33) m_mask = lb_data;
         else m_ecnt = sat(m_ecnt);
      end
      m_sticky = (old_sticky & ~w1c) | event_in;
      m_irq    = |(old_sticky & old_mask);
      m_valid  = 1'b0;
      if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
         m_valid = 1'b1;
         m_din   = m_q[0].data;
         void'(m_q.pop_front());
      end
   endtask

   initial begin
      m_cyc = 0;
      model_reset();
      forever begin
         @(posedge lb_clk or negedge lb_rstn);
         model_step();
      end
   end

   // ---------------- compare process + valid log ----------------
   bit          cmp_en = 1'b0;
   int          ncyc   = 0;
   int          we3_cnt = 0;
   int          vlog_cyc[$];
   logic [31:0] vlog_dat[$];

   initial forever begin
      @(negedge lb_clk);
      ncyc++;
      if (lb_rd_valid === 1'b1) begin
         vlog_cyc.push_back(ncyc);
         vlog_dat.push_back(lb_din);
      end
      if (ctrl_we[3] === 1'b1) we3_cnt++;
      if (cmp_en) begin
         check("rd_valid", lb_rd_valid, m_valid);
         check("lb_din", lb_din, m_din);
         check("irq", irq, m_irq);
         check("ctrl_out", ctrl_out, m_ctrl_flat());
         check("ctrl_we", ctrl_we, m_we);
      end
   end

   function automatic logic [31:0] last_dat();
      if (vlog_dat.size() > 0) return vlog_dat[vlog_dat.size()-1];
      return 32'hx;
   endfunction

   task automatic clear_log();
      vlog_cyc.delete();
      vlog_dat.delete();
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic stb, input logic rd, input logic wr,
                        input logic [23:0] a, input logic [31:0] d);
      @(negedge lb_clk);
      #1;
      lb_strobe = stb;
      lb_rd     = rd;
      lb_write  = wr;
      lb_addr   = a;
      lb_data   = d;
      event_in  = '0;
   endtask

   task automatic rd_off(input int o);
      drive(1'b1, 1'b1, 1'b0, BASE + 24'(o), 32'h0);
   endtask

   task automatic wr_off(input int o, input logic [31:0] d);
      drive(1'b1, 1'b0, 1'b1, BASE + 24'(o), d);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0, 24'h0, 32'h0);
   endtask

   task automatic do_reset(input int n);
      drive(1'b0, 1'b0, 1'b0, 24'h0, 32'h0);
      lb_rstn = 1'b0;
      repeat (n) @(negedge lb_clk);
      #1;
      lb_rstn = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      int t;
      lb_rstn = 1'b0;
      repeat (3) @(negedge lb_clk);
      cmp_en = 1'b1;
      #1;
      lb_rstn = 1'b1;

      // 1: ID read latency
      clear_log();
      rd_off(36);
      t = ncyc;
      idle(6);
      check("t1_valid_count", vlog_cyc.size(), 1);
      check("t1_latency", (vlog_cyc.size() > 0) ? vlog_cyc[0] - t : -1, 3);
      check("t1_id", last_dat(), 32'h4C524553);

      // 2: write then read-after-write
      clear_log();
      we3_cnt = 0;
      wr_off(3, 32'h12345678);
      rd_off(3);
      idle(5);
      check("t2_we_pulses", we3_cnt, 1);
      check("t2_raw", last_dat(), 32'h12345678);
      rd_off(34);
      idle(5);
      check("t2_wcnt", last_dat(), 32'd1);

      // 3: back-to-back status reads, stat_in changing each cycle
      clear_log();
      for (int k = 0; k < 4; k++) begin
         rd_off(16 + k);
         for (int j = 0; j < NS; j++) stat_in[32*j +: 32] = {8'(8'hA0 + k), 16'h0, 8'(j)};
      end
      idle(6);
      check("t3_valid_count", vlog_cyc.size(), 4);
      if (vlog_cyc.size() == 4) begin
         check("t3_consecutive", vlog_cyc[3] - vlog_cyc[0], 3);
         for (int k = 0; k < 4; k++)
            check("t3_stat", vlog_dat[k], {8'(8'hA0 + k), 16'h0, 8'(k)});
      end

      // 4: sticky / mask / irq
      wr_off(33, 32'h20);
      idle(1);
      event_in = 32'h20;
      idle(2);
      check("t4_irq_set", irq, 1'b1);
      wr_off(32, 32'h20);
      event_in = 32'h20;
      idle(2);
      rd_off(32);
      idle(4);
      check("t4_sticky_kept", last_dat(), 32'h20);
      check("t4_irq_kept", irq, 1'b1);
      wr_off(32, 32'h20);
      idle(1);
      check("t4_irq_lag", irq, 1'b1);
      idle(1);
      check("t4_irq_clear", irq, 1'b0);

      // 5: decode errors
      clear_log();
      wr_off(16, 32'hFFFF);
      rd_off(63);
      drive(1'b1, 1'b1, 1'b0, 24'h001000, 32'h0);
      rd_off(35);
      idle(5);
      check("t5_valid_count", vlog_cyc.size(), 2);
      if (vlog_dat.size() == 2) begin
         check("t5_unmapped", vlog_dat[0], 32'hDEADBEEF);
         check("t5_ecnt", vlog_dat[1], 32'd2);
      end

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         int          sel, o, kind;
         logic [23:0] a;
         sel = $urandom_range(0, 15);
         if (sel < 6)       o = $urandom_range(0, NC - 1);
         else if (sel < 9)  o = 16 + $urandom_range(0, NS - 1);
         else if (sel < 13) o = 32 + $urandom_range(0, 4);
         else               o = $urandom_range(0, 63);
         a = BASE + 24'(o);
         if ($urandom_range(0, 9) == 0) a = 24'($urandom);
         kind = $urandom_range(0, 7);
         case (kind)
            0:       drive(1'b0, 1'($urandom), 1'($urandom), a, $urandom);
            1, 2, 3: drive(1'b1, 1'b1, 1'b0, a, $urandom);
            4, 5, 6: drive(1'b1, 1'b0, 1'b1, a, $urandom);
            default: drive(1'b1, 1'b1, 1'b1, a, $urandom);
         endcase
         if ($urandom_range(0, 7) == 0) event_in = $urandom;
         for (int j = 0; j < NS; j++) stat_in[32*j +: 32] = $urandom;
         if (lb_rstn == 1'b0) lb_rstn = 1'b1;
         else if ($urandom_range(0, 399) == 0) lb_rstn = 1'b0;
      end
      idle(6);

      // 6: reset with reads in flight, then saturating write counter
      clear_log();
      rd_off(36);
      rd_off(0);
      do_reset(2);
      idle(6);
      check("t6_no_valid", vlog_cyc.size(), 0);
      check("t6_ctrl_default", ctrl_out, {NC{DEF}});
      @(negedge lb_clk);
      #1;
      force dut.wcnt_q = 32'hFFFFFFFE;
      m_wcnt = 64'hFFFFFFFE;
      @(posedge lb_clk);
      #1;
      release dut.wcnt_q;
      wr_off(0, 32'h1);
      wr_off(1, 32'h2);
      wr_off(2, 32'h3);
      rd_off(34);
      idle(5);
      check("t6_wcnt_sat", last_dat(), 32'hFFFFFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
